// File: rtl/cpu_control_unit.sv
// Accumulator CPU control unit: state register, decode and control generation; outputs are combinational from state.
// IN/OUT stall on ready/valid handshakes, up to TIMEOUT cycles before halting with a sticky error.
module cpu_control_unit #(
  parameter int IR_W    = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IR_W-1:0]  ir,
  input  logic             AnotZero,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             resume,
  output logic             IRload,
  output logic             PCload,
  output logic             JNZmux,
  output logic             INmux,
  output logic             Aload,
  output logic             OutE,
  output logic             in_ready,
  output logic             out_valid,
  output logic             halted,
  output logic             err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_IN  = 4'd3,
    EXEC_OUT = 4'd4,
    EXEC_DEC = 4'd5,
    EXEC_JNZ = 4'd6,
    HALT     = 4'd7,
    EXEC_NOP = 4'd8
  } state_t;

  localparam logic [2:0] OP_IN   = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_JNZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // A zero TIMEOUT still needs a 1-bit counter; it simply saturates.
  localparam int              WC_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX  = '1;
  localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;

  state_t          cur_state, nxt_state;
  logic [WC_W-1:0] wait_cnt;
  logic            wait_inc, set_err, clr_err, timeout_hit;
  logic [2:0]      opcode;

  assign opcode      = ir[IR_W-1 -: 3];
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == WC_LAST);
  assign state       = cur_state;
  assign halted      = (cur_state == HALT);

  generate
    if (IR_W > 3) begin : g_ir_operand
      logic unused_operand;
      assign unused_operand = ^ir[IR_W-4:0];
    end
  endgenerate

  always_comb begin
    nxt_state = cur_state;
    IRload    = 1'b0;
    PCload    = 1'b0;
    JNZmux    = 1'b0;
    INmux     = 1'b0;
    Aload     = 1'b0;
    OutE      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wait_inc  = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    case (cur_state)
      FETCH: begin
        IRload    = 1'b1;
        PCload    = 1'b1;
        nxt_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_IN:   nxt_state = EXEC_IN;
          OP_OUT:  nxt_state = EXEC_OUT;
          OP_DEC:  nxt_state = EXEC_DEC;
          OP_JNZ:  nxt_state = EXEC_JNZ;
          OP_HALT: nxt_state = HALT;
          default: nxt_state = EXEC_NOP;
        endcase
      end
      EXEC_NOP: nxt_state = FETCH;
      EXEC_DEC: begin
        Aload     = 1'b1;
        nxt_state = FETCH;
      end
      EXEC_JNZ: begin
        JNZmux    = 1'b1;
        PCload    = AnotZero;
        nxt_state = FETCH;
      end
      EXEC_IN: begin
        in_ready = 1'b1;
        // A handshake on the last allowed wait cycle still completes normally.
        if (in_valid) begin
          INmux     = 1'b1;
          Aload     = 1'b1;
          nxt_state = FETCH;
        end else if (timeout_hit) begin
          nxt_state = HALT;
          set_err   = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      EXEC_OUT: begin
        OutE      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          nxt_state = FETCH;
        end else if (timeout_hit) begin
          nxt_state = HALT;
          set_err   = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          nxt_state = FETCH;
          clr_err   = 1'b1;
        end
      end
      default: nxt_state = FETCH;
    endcase
    if (reset) begin
      IRload    = 1'b0;
      PCload    = 1'b0;
      JNZmux    = 1'b0;
      INmux     = 1'b0;
      Aload     = 1'b0;
      OutE      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= FETCH;
      wait_cnt    <= '0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      cur_state <= nxt_state;
      // Outside the I/O states the counter idles at zero, so every entry starts fresh.
      if (cur_state != EXEC_IN && cur_state != EXEC_OUT) begin
        wait_cnt <= '0;
      end else if (wait_inc && wait_cnt != WC_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
      if (cur_state == DECODE) begin
        instr_count <= instr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level reference model feeds a per-cycle expectation queue.
module tb_cpu_control_unit;
  localparam int IR_W    = 8;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [9:0] C_IRL = 10'h200;
  localparam logic [9:0] C_PCL = 10'h100;
  localparam logic [9:0] C_JNZ = 10'h080;
  localparam logic [9:0] C_INM = 10'h040;
  localparam logic [9:0] C_AL  = 10'h020;
  localparam logic [9:0] C_OE  = 10'h010;
  localparam logic [9:0] C_IRD = 10'h008;
  localparam logic [9:0] C_OV  = 10'h004;
  localparam logic [9:0] C_HLT = 10'h002;

  logic             clk = 1'b0;
  logic             reset;
  logic [IR_W-1:0]  ir;
  logic             AnotZero, in_valid, out_ready, resume;
  logic             IRload, PCload, JNZmux, INmux, Aload, OutE;
  logic             in_ready, out_valid, halted, err;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  cpu_control_unit #(.IR_W(IR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ir(ir), .AnotZero(AnotZero),
    .in_valid(in_valid), .out_ready(out_ready), .resume(resume),
    .IRload(IRload), .PCload(PCload), .JNZmux(JNZmux), .INmux(INmux),
    .Aload(Aload), .OutE(OutE), .in_ready(in_ready), .out_valid(out_valid),
    .halted(halted), .err(err), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [9:0]       ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic             err_m;
  logic [CNT_W-1:0] cnt_m;

  wire [9:0] act_ctrl = {IRload, PCload, JNZmux, INmux, Aload, OutE,
                         in_ready, out_valid, halted, err};

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (state !== e.st || act_ctrl !== e.ctrl || instr_count !== e.cnt) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: got state=%0d ctrl=%b cnt=%0d, want state=%0d ctrl=%b cnt=%0d",
                 $time, state, act_ctrl, instr_count, e.st, e.ctrl, e.cnt);
      end
    end
  end

  task automatic step(input logic [3:0] st, input logic [9:0] c);
    exp_t e;
    e.st   = st;
    e.ctrl = c | {9'b0, err_m};
    e.cnt  = cnt_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Inputs that must not matter in the current state are randomised.
  task automatic noise();
    resume    = 1'($urandom_range(0, 1));
    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    AnotZero  = 1'($urandom_range(0, 1));
  endtask

  task automatic halt_phase(input int hold);
    for (int i = 0; i < hold; i++) begin
      noise();
      resume = 1'b0;
      step(4'd7, C_HLT);
    end
    noise();
    resume = 1'b1;
    step(4'd7, C_HLT);
    err_m = 1'b0;
  endtask

  // Model: IN/OUT complete after wait_n idle cycles, unless wait_n reaches TIMEOUT.
  task automatic run_instr(input logic [2:0] op, input logic [IR_W-4:0] lo,
                           input int wait_n, input logic anz, input int hold);
    noise();
    ir = {op, lo};
    step(4'd0, C_IRL | C_PCL);
    noise();
    step(4'd1, 10'h0);
    cnt_m = cnt_m + 1'b1;
    case (op)
      3'b011: begin
        for (int i = 0; i < TIMEOUT; i++) begin
          noise();
          in_valid = (i == wait_n);
          step(4'd3, C_IRD | ((i == wait_n) ? (C_INM | C_AL) : 10'h0));
          if (i == wait_n) break;
        end
        if (wait_n >= TIMEOUT) begin
          err_m = 1'b1;
          halt_phase(hold);
        end
      end
      3'b100: begin
        for (int i = 0; i < TIMEOUT; i++) begin
          noise();
          out_ready = (i == wait_n);
          step(4'd4, C_OE | C_OV);
          if (i == wait_n) break;
        end
        if (wait_n >= TIMEOUT) begin
          err_m = 1'b1;
          halt_phase(hold);
        end
      end
      3'b101: begin
        noise();
        step(4'd5, C_AL);
      end
      3'b110: begin
        noise();
        AnotZero = anz;
        step(4'd6, C_JNZ | (anz ? C_PCL : 10'h0));
      end
      3'b111: halt_phase(hold);
      default: begin
        noise();
        step(4'd8, 10'h0);
      end
    endcase
  endtask

  initial begin
    reset = 1'b1; ir = '0; AnotZero = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; resume = 1'b0;
    err_m = 1'b0; cnt_m = '0;
    @(posedge clk);
    #1;
    step(4'd0, 10'h0);
    reset = 1'b0;

    run_instr(3'b101, 5'b00000, 0, 1'b0, 0);
    run_instr(3'b110, 5'h0a, 0, 1'b1, 0);
    run_instr(3'b110, 5'h0a, 0, 1'b0, 0);
    run_instr(3'b011, 5'h01, 3, 1'b0, 0);
    run_instr(3'b100, 5'h02, 99, 1'b0, 2);
    run_instr(3'b100, 5'h03, 3, 1'b0, 0);

    // Reset arrives while IN is waiting and in_valid is high.
    noise();
    ir = {3'b011, 5'h04};
    step(4'd0, C_IRL | C_PCL);
    noise();
    step(4'd1, 10'h0);
    cnt_m = cnt_m + 1'b1;
    noise();
    in_valid = 1'b0;
    step(4'd3, C_IRD);
    in_valid = 1'b1;
    reset = 1'b1;
    step(4'd3, 10'h0);
    err_m = 1'b0;
    cnt_m = '0;
    step(4'd0, 10'h0);
    reset = 1'b0;

    run_instr(3'b111, 5'h1f, 0, 1'b0, 10);

    for (int n = 0; n < 250; n++) begin
      run_instr(3'($urandom_range(0, 7)), (IR_W-3)'($urandom),
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Complete control unit for the accumulator CPU: state register, opcode decode and control-signal generation in one block. It generalises the fixed 3-bit execute decode with a parametrised instruction width, ready/valid handshakes on IN and OUT, and a programmable I/O wait timeout. It also adds a resumable HALT and a retired-instruction counter. It sits between the IR/PC/A datapath and the external I/O ports.

Parameters:
IR_W, 8, instruction register width; opcode = ir[IR_W-1 -: 3] (IR_W >= 3)
TIMEOUT, 16, max cycles spent waiting in EXEC_IN/EXEC_OUT; 0 disables timeout
CNT_W, 16, width of the instr_count counter

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
ir  in  IR_W  current instruction register contents
AnotZero  in  1  accumulator != 0 flag from datapath
in_valid  in  1  external input data valid
out_ready  in  1  external sink ready
resume  in  1  leave HALT (sampled only in HALT)
IRload  out  1  load IR
PCload  out  1  load/increment PC
JNZmux  out  1  select jump target into PC
INmux  out  1  select input port into A
Aload  out  1  load A
OutE  out  1  drive output port
in_ready  out  1  block ready to accept input
out_valid  out  1  output data valid
halted  out  1  state == HALT
err  out  1  sticky: an I/O wait timed out
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  instructions decoded since reset, wraps

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_IN=3, EXEC_OUT=4, EXEC_DEC=5, EXEC_JNZ=6, HALT=7, EXEC_NOP=8.
- Reset (synchronous, wins over every other event): state<=FETCH, wait counter<=0, err<=0, instr_count<=0. While reset is high, all control outputs, in_ready and out_valid are forced to 0.
- FETCH (1 cycle): IRload=1, PCload=1; next state is DECODE.
- DECODE (1 cycle): instr_count increments, wrapping modulo 2^CNT_W. Next state by opcode: 011->EXEC_IN, 100->EXEC_OUT, 101->EXEC_DEC, 110->EXEC_JNZ, 111->HALT, all other opcodes->EXEC_NOP.
- EXEC_NOP and EXEC_DEC (1 cycle each): EXEC_DEC asserts Aload=1; EXEC_NOP asserts no control outputs. Both return to FETCH.
- EXEC_JNZ (1 cycle): JNZmux=1; PCload=AnotZero, decided combinationally in the same cycle. Returns to FETCH.
- EXEC_IN:
  - in_ready=1 every cycle in this state.
  - Handshake cycle (in_valid=1): INmux=1, Aload=1 in that same cycle; next state FETCH.
  - Otherwise INmux=Aload=0; the state holds and the wait counter increments.
- EXEC_OUT:
  - OutE=1 and out_valid=1 every cycle in this state.
  - Handshake cycle (out_ready=1): next state FETCH.
  - Otherwise the state holds and the wait counter increments.
- Timeout (TIMEOUT>0): in EXEC_IN/EXEC_OUT with no handshake and wait counter == TIMEOUT-1, next state is HALT and err<=1. A handshake in that same cycle has priority: normal completion, no err.
- Wait counter: cleared on every entry to EXEC_IN/EXEC_OUT. Width is clog2(TIMEOUT+1). With TIMEOUT=0 the counter saturates and never triggers.
- HALT:
  - No control outputs asserted; halted=1.
  - resume=1 -> next state FETCH and err<=0 (err clears on the cycle HALT is exited).
  - resume is ignored in every other state.
- All control outputs are combinational from state (plus AnotZero and the handshake inputs as above). No output glitches matter; they are sampled at clk.
- Unused encodings (2, 9-15) go to FETCH on the next cycle and assert no outputs.

Test Plan:
- Reset, then ir=8'b101_00000, reset released -> FETCH (IRload=PCload=1), DECODE, EXEC_DEC (Aload=1), FETCH; instr_count=1.
- JNZ opcode 110, run twice with AnotZero=1 then 0 -> JNZmux=1 both times; PCload=1 then 0.
- IN opcode with in_valid held low 3 cycles then high -> in_ready=1 for 4 cycles; INmux=Aload=1 only on the 4th; then FETCH; err=0.
- OUT opcode, TIMEOUT=4, out_ready never asserted -> out_valid=OutE=1 for exactly 4 cycles, then HALT, err=1, halted=1; resume=1 -> FETCH, err=0.
- OUT opcode with TIMEOUT=4 and out_ready=1 exactly on the 4th wait cycle -> completes to FETCH, err stays 0.
- Assert reset during EXEC_IN wait with in_valid=1 -> next cycle state=FETCH, all outputs 0 during reset, instr_count=0; HALT opcode 111 with resume=0 for 10 cycles -> stays HALT.
